// File: rtl/wt_cache_pkg.sv
// Write-through dcache shared parameters.
// Read-port arbitration constants and port ids.
package wt_cache_pkg;

  localparam int DCACHE_CL_IDX_WIDTH = 8;
  localparam int DCACHE_OFFSET_WIDTH = 4;
  localparam int DCACHE_TAG_WIDTH    = 20;
  localparam int DCACHE_USER_WIDTH   = 8;
  localparam int DCACHE_SET_ASSOC    = 8;
  localparam int DCACHE_XLEN         = 64;

  localparam int DCACHE_NUM_RD_PORTS    = 3;
  localparam int DCACHE_RD_STARVE_LIMIT = 15;

  localparam int RD_PORT_LD   = 0;
  localparam int RD_PORT_PTW  = 1;
  localparam int RD_PORT_WBUF = 2;

  // next round-robin start after port g
  function automatic int rr_wrap(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/wt_dcache_rr_pick.sv
// Rotating-priority picker: first requester
// at or after the rr pointer, wrapping.
module wt_dcache_rr_pick #(
  parameter int NumPorts = 3,
  parameter int PtrW     = $clog2(NumPorts)
) (
  input  logic [NumPorts-1:0] req,
  input  logic [PtrW-1:0]     rr,
  output logic [NumPorts-1:0] gnt,
  output logic [PtrW-1:0]     idx,
  output logic                any
);

  // scan ports starting from rr, take the first hit
  always_comb begin
    int p;
    p   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NumPorts; k++) begin
      p = int'(rr) + k;
      if (p >= NumPorts) p = p - NumPorts;
      if (!any && req[p]) begin
        any    = 1'b1;
        idx    = PtrW'(p);
        gnt[p] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wt_dcache_rd_arb.sv
// Dcache read-port arbiter: round-robin grant,
// late tag forwarding, write-starvation bound.
module wt_dcache_rd_arb
  import wt_cache_pkg::*;
#(
  parameter int NumPorts    = DCACHE_NUM_RD_PORTS,
  parameter int IdxWidth    = DCACHE_CL_IDX_WIDTH,
  parameter int OffWidth    = DCACHE_OFFSET_WIDTH,
  parameter int TagWidth    = DCACHE_TAG_WIDTH,
  parameter int DataWidth   = DCACHE_XLEN,
  parameter int UserWidth   = DCACHE_USER_WIDTH,
  parameter int SetAssoc    = DCACHE_SET_ASSOC,
  parameter int StarveLimit = DCACHE_RD_STARVE_LIMIT
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumPorts-1:0]          rd_req_i,
  input  logic [NumPorts-1:0]          rd_tag_only_i,
  input  logic [NumPorts*IdxWidth-1:0] rd_idx_i,
  input  logic [NumPorts*OffWidth-1:0] rd_off_i,
  input  logic [NumPorts*TagWidth-1:0] rd_tag_i,
  output logic [NumPorts-1:0]          rd_ack_o,
  output logic [NumPorts-1:0]          rd_rvalid_o,
  output logic [DataWidth-1:0]         rd_data_o,
  output logic [UserWidth-1:0]         rd_user_o,
  output logic [SetAssoc-1:0]          rd_vld_bits_o,
  output logic [SetAssoc-1:0]          rd_hit_oh_o,
  input  logic                         wr_busy_i,
  output logic                         wr_stall_o,
  output logic                         mem_req_o,
  output logic                         mem_tag_only_o,
  output logic [IdxWidth-1:0]          mem_idx_o,
  output logic [OffWidth-1:0]          mem_off_o,
  output logic [TagWidth-1:0]          mem_tag_o,
  input  logic [DataWidth-1:0]         mem_data_i,
  input  logic [UserWidth-1:0]         mem_user_i,
  input  logic [SetAssoc-1:0]          mem_vld_bits_i,
  input  logic [SetAssoc-1:0]          mem_hit_oh_i
);

  localparam int PtrW = $clog2(NumPorts);
  localparam int CntW = $clog2(StarveLimit + 1);

  logic [PtrW-1:0]     rr_q;
  logic [PtrW-1:0]     sel_q;
  logic                vld_q;
  logic [CntW-1:0]     starve_q;
  logic [PtrW-1:0]     win;
  logic [NumPorts-1:0] win_oh;
  logic                win_any;
  logic                any_req;
  logic                blocked;
  logic                gnt;

  wt_dcache_rr_pick #(
    .NumPorts(NumPorts),
    .PtrW    (PtrW)
  ) u_pick (
    .req(rd_req_i),
    .rr (rr_q),
    .gnt(win_oh),
    .idx(win),
    .any(win_any)
  );

  assign any_req    = |rd_req_i;
  assign wr_stall_o = any_req &
                      (starve_q == CntW'(StarveLimit));
  assign blocked    = wr_busy_i & ~wr_stall_o;
  assign gnt        = win_any & ~blocked;

  assign rd_ack_o       = gnt ? win_oh : '0;
  assign mem_req_o      = gnt;
  assign mem_tag_only_o = gnt & rd_tag_only_i[win];
  assign mem_idx_o      = gnt ?
    rd_idx_i[win*IdxWidth +: IdxWidth] : '0;
  assign mem_off_o      = gnt ?
    rd_off_i[win*OffWidth +: OffWidth] : '0;

  assign mem_tag_o   = vld_q ?
    rd_tag_i[sel_q*TagWidth +: TagWidth] : '0;
  assign rd_rvalid_o = vld_q ?
    (NumPorts'(1) << sel_q) : '0;

  assign rd_data_o     = mem_data_i;
  assign rd_user_o     = mem_user_i;
  assign rd_vld_bits_o = mem_vld_bits_i;
  assign rd_hit_oh_o   = mem_hit_oh_i;

  // remember the owner of the response and advance rr
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q  <= '0;
      sel_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= gnt;
      if (gnt) begin
        sel_q <= win;
        rr_q  <= PtrW'(rr_wrap(int'(win), NumPorts));
      end
    end
  end

  // count write-blocked cycles with a read pending
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else if (gnt || !any_req) begin
      starve_q <= '0;
    end else if (wr_busy_i &&
                 starve_q != CntW'(StarveLimit)) begin
      starve_q <= starve_q + CntW'(1);
    end
  end

endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
// Testbench for wt_dcache_rd_arb: vector table,
// directed corner sequences, random vs model.
module tb_wt_dcache_rd_arb;
  import wt_cache_pkg::*;

  localparam int N   = DCACHE_NUM_RD_PORTS;
  localparam int IW  = DCACHE_CL_IDX_WIDTH;
  localparam int OW  = DCACHE_OFFSET_WIDTH;
  localparam int TW  = DCACHE_TAG_WIDTH;
  localparam int DW  = DCACHE_XLEN;
  localparam int UW  = DCACHE_USER_WIDTH;
  localparam int SA  = DCACHE_SET_ASSOC;
  localparam int LIM = DCACHE_RD_STARVE_LIMIT;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    rd_req_i;
  logic [N-1:0]    rd_tag_only_i;
  logic [N*IW-1:0] rd_idx_i;
  logic [N*OW-1:0] rd_off_i;
  logic [N*TW-1:0] rd_tag_i;
  logic [N-1:0]    rd_ack_o;
  logic [N-1:0]    rd_rvalid_o;
  logic [DW-1:0]   rd_data_o;
  logic [UW-1:0]   rd_user_o;
  logic [SA-1:0]   rd_vld_bits_o;
  logic [SA-1:0]   rd_hit_oh_o;
  logic            wr_busy_i;
  logic            wr_stall_o;
  logic            mem_req_o;
  logic            mem_tag_only_o;
  logic [IW-1:0]   mem_idx_o;
  logic [OW-1:0]   mem_off_o;
  logic [TW-1:0]   mem_tag_o;
  logic [DW-1:0]   mem_data_i;
  logic [UW-1:0]   mem_user_i;
  logic [SA-1:0]   mem_vld_bits_i;
  logic [SA-1:0]   mem_hit_oh_i;

  always #5 clk_i = ~clk_i;

  wt_dcache_rd_arb dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .rd_req_i      (rd_req_i),
    .rd_tag_only_i (rd_tag_only_i),
    .rd_idx_i      (rd_idx_i),
    .rd_off_i      (rd_off_i),
    .rd_tag_i      (rd_tag_i),
    .rd_ack_o      (rd_ack_o),
    .rd_rvalid_o   (rd_rvalid_o),
    .rd_data_o     (rd_data_o),
    .rd_user_o     (rd_user_o),
    .rd_vld_bits_o (rd_vld_bits_o),
    .rd_hit_oh_o   (rd_hit_oh_o),
    .wr_busy_i     (wr_busy_i),
    .wr_stall_o    (wr_stall_o),
    .mem_req_o     (mem_req_o),
    .mem_tag_only_o(mem_tag_only_o),
    .mem_idx_o     (mem_idx_o),
    .mem_off_o     (mem_off_o),
    .mem_tag_o     (mem_tag_o),
    .mem_data_i    (mem_data_i),
    .mem_user_i    (mem_user_i),
    .mem_vld_bits_i(mem_vld_bits_i),
    .mem_hit_oh_i  (mem_hit_oh_i)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h",
               nm, act, exp);
    end
  endtask

  task automatic clr_in();
    rd_req_i       = '0;
    rd_tag_only_i  = '0;
    rd_idx_i       = '0;
    rd_off_i       = '0;
    rd_tag_i       = '0;
    wr_busy_i      = 1'b0;
    mem_data_i     = '0;
    mem_user_i     = '0;
    mem_vld_bits_i = '0;
    mem_hit_oh_i   = '0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    clr_in();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         busy;
    logic [N-1:0] ack;
    logic [N-1:0] rv;
    logic         stall;
  } vec_t;

  vec_t tbl[$];

  // model state: rr pointer, starve count, owner
  int m_rr, m_st, m_resp;
  int idx_a[N], off_a[N], tag_a[N];

  task automatic run_random(input int cycles);
    int g, busy_pct;
    logic [N-1:0] req;
    logic [N-1:0] tonly;
    logic [N-1:0] e_ack, e_rv;
    logic any, stall, blk;
    m_rr = 0; m_st = 0; m_resp = -1;
    busy_pct = 50;
    for (int c = 0; c < cycles; c++) begin
      if (c % 200 == 0)
        busy_pct = (c % 400 == 0) ? 97 : 40;
      if ($urandom_range(299) == 0) begin
        do_reset();
        m_rr = 0; m_st = 0; m_resp = -1;
      end
      req   = N'($urandom);
      tonly = N'($urandom);
      rd_req_i      = req;
      rd_tag_only_i = tonly;
      wr_busy_i = ($urandom_range(99) < busy_pct);
      for (int p = 0; p < N; p++) begin
        idx_a[p] = int'($urandom_range((1 << IW) - 1));
        off_a[p] = int'($urandom_range((1 << OW) - 1));
        tag_a[p] = int'($urandom_range((1 << TW) - 1));
        rd_idx_i[p*IW +: IW] = IW'(idx_a[p]);
        rd_off_i[p*OW +: OW] = OW'(off_a[p]);
        rd_tag_i[p*TW +: TW] = TW'(tag_a[p]);
      end
      mem_data_i     = {$urandom, $urandom};
      mem_user_i     = UW'($urandom);
      mem_vld_bits_i = SA'($urandom);
      mem_hit_oh_i   = SA'($urandom);
      any   = (req != 0);
      stall = any && (m_st == LIM);
      blk   = wr_busy_i && !stall;
      g = -1;
      if (any && !blk)
        for (int k = 0; k < N; k++)
          if (g < 0 && req[(m_rr + k) % N])
            g = (m_rr + k) % N;
      e_ack = (g >= 0) ? N'(1 << g) : '0;
      e_rv  = (m_resp >= 0) ? N'(1 << m_resp) : '0;
      #1;
      chk("rnd_ack", 64'(rd_ack_o), 64'(e_ack));
      chk("rnd_req", 64'(mem_req_o), 64'(g >= 0));
      chk("rnd_stall", 64'(wr_stall_o), 64'(stall));
      chk("rnd_idx", 64'(mem_idx_o),
          (g >= 0) ? 64'(idx_a[g]) : 64'd0);
      chk("rnd_off", 64'(mem_off_o),
          (g >= 0) ? 64'(off_a[g]) : 64'd0);
      chk("rnd_tonly", 64'(mem_tag_only_o),
          (g >= 0) ? 64'(tonly[g]) : 64'd0);
      chk("rnd_rvalid", 64'(rd_rvalid_o), 64'(e_rv));
      chk("rnd_tag", 64'(mem_tag_o),
          (m_resp >= 0) ? 64'(tag_a[m_resp]) : 64'd0);
      chk("rnd_data", rd_data_o, mem_data_i);
      chk("rnd_hit", 64'(rd_hit_oh_o), 64'(mem_hit_oh_i));
      chk("rnd_vbits", 64'(rd_vld_bits_o),
          64'(mem_vld_bits_i));
      chk("rnd_user", 64'(rd_user_o), 64'(mem_user_i));
      if (g >= 0) begin
        m_rr = (g + 1) % N;
        m_st = 0;
      end else if (any && wr_busy_i) begin
        m_st = (m_st < LIM) ? m_st + 1 : LIM;
      end else begin
        m_st = 0;
      end
      m_resp = g;
      tick();
    end
  endtask

  initial begin
    clr_in();
    rst_i = 1'b1;
    #1;
    chk("rst_ack", 64'(rd_ack_o), 64'd0);
    chk("rst_rvalid", 64'(rd_rvalid_o), 64'd0);
    chk("rst_stall", 64'(wr_stall_o), 64'd0);
    chk("rst_memreq", 64'(mem_req_o), 64'd0);
    chk("rst_tag", 64'(mem_tag_o), 64'd0);
    chk("rst_idx", 64'(mem_idx_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // rotation from reset, then wrap after port 2
    for (int i = 0; i < 6; i++)
      tbl.push_back('{3'b111, 1'b0,
                      N'(1 << (i % 3)),
                      (i == 0) ? 3'b000 :
                        N'(1 << ((i - 1) % 3)),
                      1'b0});
    tbl.push_back('{3'b000, 1'b0, 3'b000, 3'b100, 1'b0});
    tbl.push_back('{3'b100, 1'b0, 3'b100, 3'b000, 1'b0});
    tbl.push_back('{3'b101, 1'b0, 3'b001, 3'b100, 1'b0});
    tbl.push_back('{3'b101, 1'b0, 3'b100, 3'b001, 1'b0});
    tbl.push_back('{3'b000, 1'b0, 3'b000, 3'b100, 1'b0});
    tbl.push_back('{3'b001, 1'b1, 3'b000, 3'b000, 1'b0});
    tbl.push_back('{3'b000, 1'b1, 3'b000, 3'b000, 1'b0});
    foreach (tbl[i]) begin
      rd_req_i  = tbl[i].req;
      wr_busy_i = tbl[i].busy;
      #1;
      chk($sformatf("tbl%0d_ack", i),
          64'(rd_ack_o), 64'(tbl[i].ack));
      chk($sformatf("tbl%0d_rv", i),
          64'(rd_rvalid_o), 64'(tbl[i].rv));
      chk($sformatf("tbl%0d_stall", i),
          64'(wr_stall_o), 64'(tbl[i].stall));
      tick();
    end

    // single port 1 read with late tag
    do_reset();
    rd_req_i = 3'b010;
    rd_idx_i[1*IW +: IW] = IW'(8'h12);
    rd_off_i[1*OW +: OW] = OW'(4'h8);
    #1;
    chk("p1_ack", 64'(rd_ack_o), 64'b010);
    chk("p1_idx", 64'(mem_idx_o), 64'h12);
    chk("p1_off", 64'(mem_off_o), 64'h8);
    chk("p1_memreq", 64'(mem_req_o), 64'd1);
    tick();
    rd_req_i = 3'b000;
    rd_tag_i[1*TW +: TW] = TW'(12'hABC);
    #1;
    chk("p1_tag", 64'(mem_tag_o), 64'hABC);
    chk("p1_rvalid", 64'(rd_rvalid_o), 64'b010);
    tick();

    // starvation bound under constant write traffic
    do_reset();
    wr_busy_i = 1'b1;
    rd_req_i  = 3'b001;
    for (int c = 1; c <= LIM; c++) begin
      #1;
      chk($sformatf("stv%0d_ack", c),
          64'(rd_ack_o), 64'd0);
      chk($sformatf("stv%0d_stall", c),
          64'(wr_stall_o), 64'd0);
      tick();
    end
    #1;
    chk("stv_stall", 64'(wr_stall_o), 64'd1);
    chk("stv_ack", 64'(rd_ack_o), 64'b001);
    tick();
    #1;
    chk("stv_after_stall", 64'(wr_stall_o), 64'd0);
    chk("stv_after_ack", 64'(rd_ack_o), 64'd0);
    chk("stv_after_rv", 64'(rd_rvalid_o), 64'b001);
    tick();

    // tag-only lookup and hit vector pass-through
    do_reset();
    rd_req_i      = 3'b001;
    rd_tag_only_i = 3'b001;
    #1;
    chk("to_flag", 64'(mem_tag_only_o), 64'd1);
    chk("to_ack", 64'(rd_ack_o), 64'b001);
    tick();
    rd_req_i      = 3'b000;
    rd_tag_only_i = 3'b000;
    mem_hit_oh_i  = 8'h04;
    #1;
    chk("to_hit", 64'(rd_hit_oh_o), 64'h04);
    chk("to_rv", 64'(rd_rvalid_o), 64'b001);
    tick();

    // reset drops the pending response and rr
    do_reset();
    rd_req_i = 3'b010;
    #1;
    chk("rm_ack", 64'(rd_ack_o), 64'b010);
    tick();
    rd_req_i = 3'b000;
    rst_i    = 1'b1;
    #1;
    chk("rm_rv_in", 64'(rd_rvalid_o), 64'd0);
    tick();
    #1;
    chk("rm_rv_hold", 64'(rd_rvalid_o), 64'd0);
    rst_i    = 1'b0;
    rd_req_i = 3'b011;
    #1;
    chk("rm_ack2", 64'(rd_ack_o), 64'b001);
    chk("rm_rv_out", 64'(rd_rvalid_o), 64'd0);
    tick();

    do_reset();
    run_random(3000);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/wt_dcache_rd_arb.md
Name: wt_dcache_rd_arb

Overview:
- Shares the single read port of the write-through dcache memory (tag + data arrays) among NumPorts read controllers: load units, PTW and the write-buffer tag check.
- Provides round-robin grant, index/offset muxing in the request cycle and tag forwarding in the following cycle. The tag arrives late from the TLB.
- Routes the response one cycle after grant back to the owner.
- Bounds read starvation behind write-port traffic with a saturating counter.

Parameters:
- NumPorts, 3, number of read requesters (>=2)
- IdxWidth, DCACHE_CL_IDX_WIDTH, cacheline index width
- OffWidth, DCACHE_OFFSET_WIDTH, byte offset width
- TagWidth, DCACHE_TAG_WIDTH, tag width
- DataWidth, riscv::XLEN, read data width
- UserWidth, DCACHE_USER_WIDTH, user bits width
- SetAssoc, DCACHE_SET_ASSOC, number of ways
- StarveLimit, 15, max consecutive write-blocked cycles with a pending read (>=1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- rd_req_i  in  NumPorts  read request per port; held until acked
- rd_tag_only_i  in  NumPorts  tag-only lookup per port
- rd_idx_i  in  NumPorts*IdxWidth  index per port
- rd_off_i  in  NumPorts*OffWidth  offset per port
- rd_tag_i  in  NumPorts*TagWidth  tag per port, sampled one cycle after ack
- rd_ack_o  out  NumPorts  one-hot grant
- rd_rvalid_o  out  NumPorts  one-hot response valid, one cycle after ack
- rd_data_o  out  DataWidth  broadcast read data
- rd_user_o  out  UserWidth  broadcast user bits
- rd_vld_bits_o  out  SetAssoc  broadcast valid bits of the indexed set
- rd_hit_oh_o  out  SetAssoc  broadcast one-hot hit vector
- wr_busy_i  in  1  write port owns the arrays this cycle; blocks reads
- wr_stall_o  out  1  write port must yield this cycle
- mem_req_o  out  1  read strobe to arrays
- mem_tag_only_o  out  1  tag-only read
- mem_idx_o  out  IdxWidth  index to arrays
- mem_off_o  out  OffWidth  offset to arrays
- mem_tag_o  out  TagWidth  compare tag, cycle after mem_req_o
- mem_data_i  in  DataWidth  way-selected data, cycle after mem_req_o
- mem_user_i  in  UserWidth  user bits
- mem_vld_bits_i  in  SetAssoc  set valid bits
- mem_hit_oh_i  in  SetAssoc  hit vector

Behaviour:
- Reset values:
  - rr_q=0, sel_q=0, vld_q=0, starve_q=0.
  - All outputs 0. Combinational outputs are 0 given no requests.
- blocked = wr_busy_i & ~wr_stall_o.
- Request cycle T, combinational:
  - If |rd_req_i and !blocked, the winner g is the first requesting port at or after rr_q, wrapping modulo NumPorts.
  - rd_ack_o[g]=1 and mem_req_o=1.
  - mem_idx_o, mem_off_o and mem_tag_only_o are taken from port g.
  - When there is no grant, mem_idx_o, mem_off_o and mem_tag_only_o are 0.
- Grant registers: on grant, sel_q<=g, vld_q<=1 and rr_q<=(g+1) mod NumPorts. With no grant, vld_q<=0 and rr_q holds.
- Response cycle T+1:
  - mem_tag_o = rd_tag_i[sel_q] when vld_q, else 0.
  - rd_rvalid_o = vld_q ? onehot(sel_q) : 0.
  - rd_data_o, rd_user_o, rd_vld_bits_o and rd_hit_oh_o pass mem_*_i through unregistered.
- Pipelining: back-to-back grants are allowed every cycle. A response at T+1 and a new grant at T+1 coexist.
- Starvation counter:
  - starve_q increments when |rd_req_i & wr_busy_i & no grant. It saturates at StarveLimit.
  - wr_stall_o = (starve_q==StarveLimit) & |rd_req_i. While asserted, reads are arbitrated despite wr_busy_i.
  - starve_q<=0 on any read grant, and also when no read is pending.
- A requester dropping rd_req_i before ack is legal: its request is lost and no response is produced.
- A port acked twice in consecutive cycles receives two rvalids in consecutive cycles.
- Reset mid-operation: an outstanding response is discarded (rd_rvalid_o=0 during and after reset). Requesters re-issue.
- The response path does not check the hit vector for one-hot; that check belongs to the controllers.

Decomposition:
- wt_cache_pkg: add DCACHE_NUM_RD_PORTS = 3 and DCACHE_RD_STARVE_LIMIT = 15. Port-index constants (LD=0, PTW=1, WBUF=2) also go in this package.
- Sub-module wt_dcache_rr_pick: combinational rotating-priority picker.
  - Inputs: req vector, rr pointer.
  - Outputs: one-hot grant, binary index, any.
- Registers and the starvation counter stay in the top module.

Test Plan:
1. Port 1 only: req with idx=0x12, off=0x8; rd_tag_i[1]=0xABC in the next cycle -> rd_ack_o=3'b010 and mem_idx_o=0x12 in cycle T; in T+1, mem_tag_o=0xABC and rd_rvalid_o=3'b010.
2. All three ports held requesting for 6 cycles, rr_q=0 -> acks 001,010,100,001,010,100 in consecutive cycles; rvalid is the same pattern delayed by one cycle.
3. After a grant to port 2, ports 0 and 2 request -> next ack 3'b001 (wrap); then 3'b100.
4. wr_busy_i=1 constantly, port 0 requesting, StarveLimit=15 -> no ack for 15 cycles; cycle 16: wr_stall_o=1, rd_ack_o=3'b001; cycle 17: starve_q=0, wr_stall_o=0.
5. Port 0 with rd_tag_only_i=1 -> mem_tag_only_o=1 in the grant cycle. mem_hit_oh_i=8'h04 in T+1 -> rd_hit_oh_o=8'h04 with rd_rvalid_o=3'b001.
6. rst_i pulsed in the cycle after a grant to port 1 -> rd_rvalid_o=0 throughout; after release, port 0 and port 1 requesting -> ack 3'b001 (rr_q reset to 0).
